systolic_gemm_engine: RTL and testbench

//  Handshaked, parametrised output-stationary systolic GEMM: C[ROWS][COLS] = A[ROWS][K_DIM] x B[K_DIM][COLS].

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/systolic_gemm_engine_mac_pe.sv | 63 ++++++
 rtl/systolic_gemm_engine.sv | 197 +++++++++++++++++++
 tb/tb_systolic_gemm_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic GEMM engine.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // Width of the skew counter that walks the operand wavefronts through FEED.
  localparam int SKEW_CNT_W = 8;

  // Cycles from the accepting clock edge to the done pulse.
  function automatic int gemm_latency(input int rows, input int cols, input int k);
    return k + rows + cols + 1;
  endfunction

endpackage

// File: rtl/systolic_gemm_engine_mac_pe.sv
// One processing element of the output-stationary array: a multiply-accumulate
// with signed/unsigned operand extension, clear/preload of the accumulator,
// and registered pass-through of A eastwards and B southwards.
module mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              signed_mode,
  input  logic              clear,
  input  logic              preload,
  input  logic [ACC_W-1:0]  preload_value,
  input  logic              mac_en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;
  logic [ACC_W-1:0] product;

  // Extend both operands to the accumulator width so the product wraps modulo 2^ACC_W.
  always_comb begin
    if (signed_mode) begin
      a_ext = {{(ACC_W-DATA_W){a_in[DATA_W-1]}}, a_in};
      b_ext = {{(ACC_W-DATA_W){b_in[DATA_W-1]}}, b_in};
    end else begin
      a_ext = {{(ACC_W-DATA_W){1'b0}}, a_in};
      b_ext = {{(ACC_W-DATA_W){1'b0}}, b_in};
    end
    product = a_ext * b_ext;
  end

  // Accumulator and pass registers; a new job flushes the pipes so no stale operands leak in.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (clear) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (preload) begin
      acc   <= preload_value;
      a_out <= '0;
      b_out <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (mac_en) begin
        acc <= acc + product;
      end
    end
  end

endmodule

// File: rtl/systolic_gemm_engine.sv
// Handshaked output-stationary systolic GEMM: C = A x B with start/busy/done
// control, per-job signed mode and accumulate-onto-previous-result mode.
module systolic_gemm_engine
  import systolic_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16,
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int K_DIM  = 3
) (
  input  logic                                    clock,
  input  logic                                    nreset,
  input  logic                                    start,
  input  logic                                    signed_mode,
  input  logic                                    accumulate,
  input  logic [ROWS-1:0][K_DIM-1:0][DATA_W-1:0]  a_input,
  input  logic [K_DIM-1:0][COLS-1:0][DATA_W-1:0]  b_input,
  output logic                                    busy,
  output logic                                    done,
  output logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]    c_out
);

  // FEED length is the total latency minus the LOAD, DRAIN and DONE cycles.
  localparam int FEED_CYCLES = gemm_latency(ROWS, COLS, K_DIM) - 3;
  localparam logic [SKEW_CNT_W-1:0] LAST_T = SKEW_CNT_W'(FEED_CYCLES - 1);

  state_t state;
  state_t next_state;

  logic                   accept;
  logic                   pe_load;
  logic                   feed_en;
  logic                   mac_en;
  logic                   capture;
  logic [SKEW_CNT_W-1:0]  t_cnt;

  logic [ROWS-1:0][K_DIM-1:0][DATA_W-1:0] a_reg;
  logic [K_DIM-1:0][COLS-1:0][DATA_W-1:0] b_reg;
  logic                                   signed_reg;
  logic                                   accum_reg;

  logic [DATA_W-1:0] row_next [ROWS];
  logic [DATA_W-1:0] col_next [COLS];
  logic [DATA_W-1:0] row_feed [ROWS];
  logic [DATA_W-1:0] col_feed [COLS];

  logic [DATA_W-1:0] a_link [ROWS][COLS+1];
  logic [DATA_W-1:0] b_link [ROWS+1][COLS];
  logic [ACC_W-1:0]  pe_acc [ROWS][COLS];

  // The done cycle still counts as busy so a start arriving with done is refused.
  assign busy = (state != IDLE) || done;

  // State register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one LOAD, FEED for the skew window, one DRAIN, one DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && !done) next_state = LOAD;
      LOAD:    next_state = FEED;
      FEED:    if (t_cnt == LAST_T) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    accept  = 1'b0;
    pe_load = 1'b0;
    feed_en = 1'b0;
    mac_en  = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE:    accept = start && !done;
      LOAD:    pe_load = 1'b1;
      FEED: begin
        feed_en = 1'b1;
        mac_en  = 1'b1;
      end
      DRAIN:   mac_en = 1'b1;
      DONE:    capture = 1'b1;
      default: ;
    endcase
  end

  // Skew counter: restarts in LOAD and advances once per FEED cycle.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      t_cnt <= '0;
    end else if (pe_load) begin
      t_cnt <= '0;
    end else if (feed_en) begin
      t_cnt <= t_cnt + 1'b1;
    end
  end

  // Operands and mode bits are latched on accept so the input buses are free afterwards.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      accum_reg  <= 1'b0;
    end else if (accept) begin
      a_reg      <= a_input;
      b_reg      <= b_input;
      signed_reg <= signed_mode;
      accum_reg  <= accumulate;
    end
  end

  // Skewed edge values: row i carries A[i][t-i], column j carries B[t-j][j], zero outside the window.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      row_next[i] = '0;
      for (int k = 0; k < K_DIM; k++) begin
        if (feed_en && (t_cnt == SKEW_CNT_W'(i + k))) row_next[i] = a_reg[i][k];
      end
    end
    for (int j = 0; j < COLS; j++) begin
      col_next[j] = '0;
      for (int k = 0; k < K_DIM; k++) begin
        if (feed_en && (t_cnt == SKEW_CNT_W'(j + k))) col_next[j] = b_reg[k][j];
      end
    end
  end

  // Edge feeder registers driving the west column and north row of the array.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < ROWS; i++) row_feed[i] <= '0;
      for (int j = 0; j < COLS; j++) col_feed[j] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++) row_feed[i] <= row_next[i];
      for (int j = 0; j < COLS; j++) col_feed[j] <= col_next[j];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_edge
    assign a_link[gi][0] = row_feed[gi];
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_col_edge
    assign b_link[0][gj] = col_feed[gj];
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_pe_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe_col
      mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clock         (clock),
        .nreset        (nreset),
        .signed_mode   (signed_reg),
        .clear         (pe_load && !accum_reg),
        .preload       (pe_load && accum_reg),
        .preload_value (c_out[gi][gj]),
        .mac_en        (mac_en),
        .a_in          (a_link[gi][gj]),
        .b_in          (b_link[gi][gj]),
        .a_out         (a_link[gi][gj+1]),
        .b_out         (b_link[gi+1][gj]),
        .acc           (pe_acc[gi][gj])
      );
    end
  end

  // Result register and done pulse, both updated on the edge that ends DONE.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      c_out <= '0;
      done  <= 1'b0;
    end else begin
      done <= capture;
      if (capture) begin
        for (int i = 0; i < ROWS; i++) begin
          for (int j = 0; j < COLS; j++) begin
            c_out[i][j] <= pe_acc[i][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// Self-checking bench for systolic_gemm_engine: a 3x3x3 build for the directed
// scenarios and a 2x4x5 build checked against a reference model on random data.
module tb_systolic_gemm_engine;

  typedef logic [2:0][2:0][3:0]  mat_a_t;
  typedef logic [2:0][2:0][15:0] mat_c_t;
  typedef logic [1:0][4:0][3:0]  rect_a_t;
  typedef logic [4:0][3:0][3:0]  rect_b_t;
  typedef logic [1:0][3:0][15:0] rect_c_t;

  logic   clock;
  logic   nreset;

  logic   start;
  logic   signed_mode;
  logic   accumulate;
  mat_a_t a_input;
  mat_a_t b_input;
  logic   busy;
  logic   done;
  mat_c_t c_out;

  logic    start_r;
  logic    signed_r;
  logic    accum_r;
  rect_a_t a_r;
  rect_b_t b_r;
  logic    busy_r;
  logic    done_r;
  rect_c_t c_r;

  int check_count;
  int fail_count;

  mat_c_t  exp_q [$];
  rect_c_t exp_r_q [$];
  mat_c_t  model_c;
  rect_c_t model_r_c;

  mat_a_t ident, b1, all_f, all_8, all_7;
  mat_c_t eb, e2b;

  systolic_gemm_engine #(
    .DATA_W (4), .ACC_W (16), .ROWS (3), .COLS (3), .K_DIM (3)
  ) dut (
    .clock       (clock),
    .nreset      (nreset),
    .start       (start),
    .signed_mode (signed_mode),
    .accumulate  (accumulate),
    .a_input     (a_input),
    .b_input     (b_input),
    .busy        (busy),
    .done        (done),
    .c_out       (c_out)
  );

  systolic_gemm_engine #(
    .DATA_W (4), .ACC_W (16), .ROWS (2), .COLS (4), .K_DIM (5)
  ) dut_rect (
    .clock       (clock),
    .nreset      (nreset),
    .start       (start_r),
    .signed_mode (signed_r),
    .accumulate  (accum_r),
    .a_input     (a_r),
    .b_input     (b_r),
    .busy        (busy_r),
    .done        (done_r),
    .c_out       (c_r)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int elem(input logic [3:0] v, input logic sm);
    return sm ? int'($signed(v)) : int'(v);
  endfunction

  function automatic mat_c_t gemm_model(input mat_a_t a, input mat_a_t b, input logic sm, input mat_c_t base);
    mat_c_t r;
    int sum;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        sum = int'(base[i][j]);
        for (int k = 0; k < 3; k++) sum += elem(a[i][k], sm) * elem(b[k][j], sm);
        r[i][j] = 16'(sum);
      end
    end
    return r;
  endfunction

  function automatic rect_c_t rect_model(input rect_a_t a, input rect_b_t b, input logic sm, input rect_c_t base);
    rect_c_t r;
    int sum;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) begin
        sum = int'(base[i][j]);
        for (int k = 0; k < 5; k++) sum += elem(a[i][k], sm) * elem(b[k][j], sm);
        r[i][j] = 16'(sum);
      end
    end
    return r;
  endfunction

  function automatic mat_a_t rand_mat();
    mat_a_t r;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) r[i][k] = 4'($urandom());
    return r;
  endfunction

  // Runs one job on the 3x3x3 build; optionally keeps start high with junk data for the whole job.
  task automatic applyStimulus(input logic sm, input logic acc, input mat_a_t a, input mat_a_t b, input logic spam);
    mat_c_t expected;
    int     cyc;
    int     extra;
    logic   busy_ok;
    expected = gemm_model(a, b, sm, acc ? model_c : '0);
    model_c  = expected;
    exp_q.push_back(expected);
    signed_mode = sm;
    accumulate  = acc;
    a_input     = a;
    b_input     = b;
    start       = 1'b1;
    tick();
    start       = spam;
    signed_mode = ~sm;
    accumulate  = ~acc;
    a_input     = rand_mat();
    b_input     = rand_mat();
    cyc     = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 60) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      cyc++;
      if (spam) begin
        a_input = rand_mat();
        b_input = rand_mat();
      end
    end
    start = 1'b0;
    checkOutput("busy_during_job", 256'(busy_ok), 256'(1'b1));
    checkOutput("done_latency", 256'(cyc), 256'(10));
    checkOutput("busy_at_done", 256'(busy), 256'(1'b1));
    if (exp_q.size() > 0) checkOutput("c_out", 256'(c_out), 256'(exp_q.pop_front()));
    else checkOutput("scoreboard_underflow", 256'(exp_q.size()), 256'(1));
    tick();
    checkOutput("done_pulse_width", 256'(done), 256'(1'b0));
    checkOutput("busy_after_done", 256'(busy), 256'(1'b0));
    checkOutput("c_out_held", 256'(c_out), 256'(expected));
    if (spam) begin
      extra = 0;
      repeat (15) begin
        tick();
        if (busy || done) extra++;
      end
      checkOutput("spam_no_extra_job", 256'(extra), 256'(0));
    end
  endtask

  // Runs one random job on the 2x4x5 build against the reference model.
  task automatic applyStimulusRect(input logic sm, input logic acc);
    rect_a_t a;
    rect_b_t b;
    rect_c_t expected;
    int      cyc;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 5; k++) a[i][k] = 4'($urandom());
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 4; j++) b[k][j] = 4'($urandom());
    expected  = rect_model(a, b, sm, acc ? model_r_c : '0);
    model_r_c = expected;
    exp_r_q.push_back(expected);
    signed_r = sm;
    accum_r  = acc;
    a_r      = a;
    b_r      = b;
    start_r  = 1'b1;
    tick();
    start_r  = 1'b0;
    a_r      = ~a;
    b_r      = ~b;
    cyc = 0;
    while (!done_r && cyc < 60) begin
      tick();
      cyc++;
    end
    checkOutput("rect_latency", 256'(cyc), 256'(12));
    if (exp_r_q.size() > 0) checkOutput("rect_c_out", 256'(c_r), 256'(exp_r_q.pop_front()));
    else checkOutput("rect_scoreboard_underflow", 256'(exp_r_q.size()), 256'(1));
    tick();
    checkOutput("rect_done_pulse_width", 256'(done_r), 256'(1'b0));
  endtask

  initial begin
    check_count = 0;
    fail_count  = 0;
    nreset      = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    accumulate  = 1'b0;
    a_input     = '0;
    b_input     = '0;
    start_r     = 1'b0;
    signed_r    = 1'b0;
    accum_r     = 1'b0;
    a_r         = '0;
    b_r         = '0;
    model_c     = '0;
    model_r_c   = '0;

    ident = '0;
    for (int i = 0; i < 3; i++) ident[i][i] = 4'd1;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) begin
        b1[k][j]  = 4'(3 * k + j + 1);
        eb[k][j]  = 16'(3 * k + j + 1);
        e2b[k][j] = 16'(2 * (3 * k + j + 1));
        all_f[k][j] = 4'hF;
        all_8[k][j] = 4'h8;
        all_7[k][j] = 4'h7;
      end

    #3;
    checkOutput("reset_busy", 256'(busy), 256'(1'b0));
    checkOutput("reset_done", 256'(done), 256'(1'b0));
    checkOutput("reset_c_out", 256'(c_out), 256'(0));
    checkOutput("reset_rect_busy", 256'(busy_r), 256'(1'b0));
    checkOutput("reset_rect_c_out", 256'(c_r), 256'(0));
    tick();
    nreset = 1'b1;
    tick();

    $display("[TB] identity times B");
    applyStimulus(1'b0, 1'b0, ident, b1, 1'b0);
    checkOutput("t1_c_equals_b", 256'(c_out), 256'(eb));

    $display("[TB] accumulate onto previous result");
    applyStimulus(1'b0, 1'b1, ident, b1, 1'b0);
    checkOutput("t4_accum_2b", 256'(c_out), 256'(e2b));

    $display("[TB] all ones unsigned");
    applyStimulus(1'b0, 1'b0, all_f, all_f, 1'b0);
    checkOutput("t2_elem_675", 256'(c_out[1][2]), 256'(16'd675));

    $display("[TB] signed versus unsigned");
    applyStimulus(1'b1, 1'b0, all_8, all_7, 1'b0);
    checkOutput("t3_signed_elem", 256'(c_out[2][0]), 256'(16'hFF58));
    applyStimulus(1'b0, 1'b0, all_8, all_7, 1'b0);
    checkOutput("t3_unsigned_elem", 256'(c_out[0][1]), 256'(16'd168));

    $display("[TB] start held during job");
    applyStimulus(1'b0, 1'b0, ident, b1, 1'b1);
    checkOutput("t5_first_job_only", 256'(c_out), 256'(eb));

    $display("[TB] reset mid-job");
    a_input = all_f;
    b_input = all_f;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (4) tick();
    nreset = 1'b0;
    #1;
    checkOutput("t6_abort_busy", 256'(busy), 256'(1'b0));
    checkOutput("t6_abort_done", 256'(done), 256'(1'b0));
    checkOutput("t6_abort_c_out", 256'(c_out), 256'(0));
    model_c   = '0;
    model_r_c = '0;
    tick();
    nreset = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, ident, b1, 1'b0);
    checkOutput("t6_fresh_job", 256'(c_out), 256'(eb));

    $display("[TB] rectangular build, random data");
    repeat (6) applyStimulusRect(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
